// File: rtl/uart_tx_frame_ctrl_if.sv
// Parallel-side and serial-side signal bundle for uart_tx_frame_ctrl.
// master = word source (FIFO read side), slave = transmit controller.
interface uart_tx_frame_ctrl_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] P_DATA;
  logic                  Data_Valid;
  logic                  PAR_EN;
  logic                  PAR_TYP;
  logic                  STOP2;
  logic                  TX_OUT;
  logic                  busy;
  logic                  tx_done;

  modport master (
    output P_DATA, Data_Valid, PAR_EN, PAR_TYP, STOP2,
    input  TX_OUT, busy, tx_done
  );

  modport slave (
    input  P_DATA, Data_Valid, PAR_EN, PAR_TYP, STOP2,
    output TX_OUT, busy, tx_done
  );
endinterface

// File: rtl/uart_tx_frame_ctrl.sv
// UART transmit framer: start, LSB-first data, optional parity, 1/2 stop bits, one bit per CLK.
// Define UART_TX_B2B_EN to let a request in the last stop cycle chain straight into the next start bit.
module uart_tx_frame_ctrl #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                 CLK,
  input  logic                 RST,
  uart_tx_frame_ctrl_if.slave  bus
);

  localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DATA_WIDTH - 1);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP1  = 3'd4;
  localparam logic [2:0] ST_STOP2  = 3'd5;

  logic [2:0]            state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  par_en_q, par_en_d;
  logic                  par_typ_q, par_typ_d;
  logic                  stop2_q, stop2_d;
  logic                  tx_q, tx_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  accept;
  logic                  frame_end;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
    par_en_d  = par_en_q;
    par_typ_d = par_typ_q;
    stop2_d   = stop2_q;
    accept    = 1'b0;
    frame_end = 1'b0;

    case (state_q)
      ST_IDLE: begin
        accept = bus.Data_Valid;
      end
      ST_START: begin
        state_d = ST_DATA;
        cnt_d   = '0;
      end
      ST_DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = par_en_q ? ST_PARITY : ST_STOP1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_PARITY: begin
        state_d = ST_STOP1;
      end
      ST_STOP1: begin
        if (stop2_q) begin
          state_d = ST_STOP2;
        end else begin
          frame_end = 1'b1;
        end
      end
      ST_STOP2: begin
        frame_end = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    if (frame_end) begin
      state_d = ST_IDLE;
`ifdef UART_TX_B2B_EN
      accept = bus.Data_Valid;
`endif
    end

    // Word and config are captured only here, so the source may change them freely mid-frame
    if (accept) begin
      data_d    = bus.P_DATA;
      par_en_d  = bus.PAR_EN;
      par_typ_d = bus.PAR_TYP;
      stop2_d   = bus.STOP2;
      cnt_d     = '0;
      state_d   = ST_START;
    end

    done_d = frame_end;
    busy_d = (state_d != ST_IDLE);

    // Line level is registered from the next state so TX_OUT never passes through logic
    case (state_d)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = data_d[cnt_d];
      ST_PARITY: tx_d = (^data_d) ^ par_typ_d;
      default:   tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      data_q    <= '0;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      stop2_q   <= 1'b0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      data_q    <= data_d;
      par_en_q  <= par_en_d;
      par_typ_q <= par_typ_d;
      stop2_q   <= stop2_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign bus.TX_OUT  = tx_q;
  assign bus.busy    = busy_q;
  assign bus.tx_done = done_q;

endmodule

// File: tb/tb_uart_tx_frame_ctrl.sv
// Directed self-checking bench for uart_tx_frame_ctrl; expectations adapt to UART_TX_B2B_EN.
module tb_uart_tx_frame_ctrl;

  localparam int DW = 8;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  uart_tx_frame_ctrl_if #(.DATA_WIDTH(DW)) bus ();

  uart_tx_frame_ctrl #(.DATA_WIDTH(DW)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Presents a request for one edge; on return the first frame cycle (start bit) is visible
  task automatic request(input logic [7:0] d, input logic pe, input logic pt, input logic s2);
    bus.P_DATA     = d;
    bus.PAR_EN     = pe;
    bus.PAR_TYP    = pt;
    bus.STOP2      = s2;
    bus.Data_Valid = 1'b1;
    tick();
    bus.Data_Valid = 1'b0;
  endtask

  task automatic test_reset();
    bus.P_DATA     = '0;
    bus.Data_Valid = 1'b0;
    bus.PAR_EN     = 1'b0;
    bus.PAR_TYP    = 1'b0;
    bus.STOP2      = 1'b0;
    tick();
    tick();
    n_checks++;
    if (bus.TX_OUT !== 1'b1 || bus.busy !== 1'b0 || bus.tx_done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: TX_OUT=%b busy=%b tx_done=%b, expected 1 0 0",
               bus.TX_OUT, bus.busy, bus.tx_done);
    end
    #2 RST = 1'b1;
    tick();
    tick();
    n_checks++;
    if (bus.TX_OUT !== 1'b1 || bus.busy !== 1'b0 || bus.tx_done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_idle: TX_OUT=%b busy=%b tx_done=%b, expected 1 0 0",
               bus.TX_OUT, bus.busy, bus.tx_done);
    end
    $display("reset: released, line idle");
  endtask

  task automatic test_parity_even();
    logic [0:11] exp_bits;
    exp_bits = 12'b0101_0010_1010;
    request(8'hA5, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 11; i++) begin
      n_checks++;
      if (bus.TX_OUT !== exp_bits[i] || bus.busy !== 1'b1 || bus.tx_done !== 1'b0) begin
        n_fail++;
        $display("FAIL even_bit%0d: TX_OUT=%b busy=%b tx_done=%b, expected %b 1 0",
                 i, bus.TX_OUT, bus.busy, bus.tx_done, exp_bits[i]);
      end
      tick();
    end
    n_checks++;
    if (bus.tx_done !== 1'b1 || bus.busy !== 1'b0 || bus.TX_OUT !== 1'b1) begin
      n_fail++;
      $display("FAIL even_end: tx_done=%b busy=%b TX_OUT=%b, expected 1 0 1",
               bus.tx_done, bus.busy, bus.TX_OUT);
    end
    tick();
    n_checks++;
    if (bus.tx_done !== 1'b0) begin
      n_fail++;
      $display("FAIL even_done_width: tx_done=%b, expected 0", bus.tx_done);
    end
    $display("frame 0xA5 even parity, 1 stop: 11 cycles");
  endtask

  task automatic test_parity_odd_stop2();
    logic [0:11] exp_bits;
    exp_bits = 12'b0100_0000_0011;
    request(8'h01, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 12; i++) begin
      n_checks++;
      if (bus.TX_OUT !== exp_bits[i] || bus.busy !== 1'b1 || bus.tx_done !== 1'b0) begin
        n_fail++;
        $display("FAIL odd_bit%0d: TX_OUT=%b busy=%b tx_done=%b, expected %b 1 0",
                 i, bus.TX_OUT, bus.busy, bus.tx_done, exp_bits[i]);
      end
      tick();
    end
    n_checks++;
    if (bus.tx_done !== 1'b1 || bus.busy !== 1'b0 || bus.TX_OUT !== 1'b1) begin
      n_fail++;
      $display("FAIL odd_end: tx_done=%b busy=%b TX_OUT=%b, expected 1 0 1",
               bus.tx_done, bus.busy, bus.TX_OUT);
    end
    tick();
    $display("frame 0x01 odd parity, 2 stop: 12 cycles");
  endtask

  task automatic test_data_latch();
    logic [0:11] exp_bits;
    exp_bits = 12'b0111_1111_1100;
    request(8'hFF, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      if (i == 2) begin
        bus.P_DATA  = 8'h00;
        bus.PAR_EN  = 1'b1;
        bus.STOP2   = 1'b1;
      end
      n_checks++;
      if (bus.TX_OUT !== exp_bits[i] || bus.busy !== 1'b1) begin
        n_fail++;
        $display("FAIL latch_bit%0d: TX_OUT=%b busy=%b, expected %b 1",
                 i, bus.TX_OUT, bus.busy, exp_bits[i]);
      end
      tick();
    end
    n_checks++;
    if (bus.tx_done !== 1'b1 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL latch_end: tx_done=%b busy=%b, expected 1 0", bus.tx_done, bus.busy);
    end
    tick();
    $display("frame 0xFF no parity, inputs changed mid-frame: 10 cycles");
  endtask

  task automatic test_ignore_busy();
    logic [0:11] exp_bits;
    int          done_cnt;
    exp_bits = 12'b0001_1110_0100;
    done_cnt = 0;
    request(8'h3C, 1'b0, 1'b0, 1'b0);
    bus.P_DATA = 8'h00;
    for (int i = 0; i < 10; i++) begin
      bus.Data_Valid = (i == 3 || i == 6);
      n_checks++;
      if (bus.TX_OUT !== exp_bits[i] || bus.busy !== 1'b1) begin
        n_fail++;
        $display("FAIL ignore_bit%0d: TX_OUT=%b busy=%b, expected %b 1",
                 i, bus.TX_OUT, bus.busy, exp_bits[i]);
      end
      tick();
    end
    bus.Data_Valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (bus.tx_done === 1'b1) done_cnt++;
      n_checks++;
      if (bus.busy !== 1'b0 || bus.TX_OUT !== 1'b1) begin
        n_fail++;
        $display("FAIL ignore_idle%0d: busy=%b TX_OUT=%b, expected 0 1", i, bus.busy, bus.TX_OUT);
      end
      tick();
    end
    n_checks++;
    if (done_cnt != 1) begin
      n_fail++;
      $display("FAIL ignore_done_count: got %0d pulses, expected 1", done_cnt);
    end
    $display("frame 0x3C with requests while busy: one frame sent");
  endtask

  task automatic test_reset_mid_frame();
    logic [0:11] exp_bits;
    exp_bits = 12'b0010_1101_0011;
    request(8'hA5, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) tick();
    #2 RST = 1'b0;
    #1;
    n_checks++;
    if (bus.TX_OUT !== 1'b1 || bus.busy !== 1'b0 || bus.tx_done !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_async: TX_OUT=%b busy=%b tx_done=%b, expected 1 0 0",
               bus.TX_OUT, bus.busy, bus.tx_done);
    end
    tick();
    #2 RST = 1'b1;
    tick();
    n_checks++;
    if (bus.TX_OUT !== 1'b1 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_idle: TX_OUT=%b busy=%b, expected 1 0", bus.TX_OUT, bus.busy);
    end
    request(8'h5A, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 12; i++) begin
      n_checks++;
      if (bus.TX_OUT !== exp_bits[i] || bus.busy !== 1'b1) begin
        n_fail++;
        $display("FAIL after_abort_bit%0d: TX_OUT=%b busy=%b, expected %b 1",
                 i, bus.TX_OUT, bus.busy, exp_bits[i]);
      end
      tick();
    end
    n_checks++;
    if (bus.tx_done !== 1'b1 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL after_abort_end: tx_done=%b busy=%b, expected 1 0", bus.tx_done, bus.busy);
    end
    tick();
    $display("reset during data bit 4, then frame 0x5A even parity 2 stop");
  endtask

  task automatic test_back_to_back();
    logic [0:21] exp_tx;
    logic [0:21] exp_busy;
    logic [0:21] exp_done;
    int          drop_at;
`ifdef UART_TX_B2B_EN
    exp_tx   = 22'b0101010101_0010101011_11;
    exp_busy = 22'b1111111111_1111111111_00;
    exp_done = 22'b0000000000_1000000000_10;
    drop_at  = 10;
`else
    exp_tx   = 22'b0101010101_1_0010101011_1;
    exp_busy = 22'b1111111111_0_1111111111_0;
    exp_done = 22'b0000000000_1_0000000000_1;
    drop_at  = 11;
`endif
    bus.P_DATA     = 8'h55;
    bus.PAR_EN     = 1'b0;
    bus.PAR_TYP    = 1'b0;
    bus.STOP2      = 1'b0;
    bus.Data_Valid = 1'b1;
    tick();
    bus.P_DATA = 8'hAA;
    for (int i = 0; i < 22; i++) begin
      if (i == drop_at) bus.Data_Valid = 1'b0;
      n_checks++;
      if (bus.TX_OUT !== exp_tx[i] || bus.busy !== exp_busy[i] || bus.tx_done !== exp_done[i]) begin
        n_fail++;
        $display("FAIL b2b_cycle%0d: TX_OUT=%b busy=%b tx_done=%b, expected %b %b %b",
                 i, bus.TX_OUT, bus.busy, bus.tx_done, exp_tx[i], exp_busy[i], exp_done[i]);
      end
      tick();
    end
    $display("frames 0x55 then 0xAA with Data_Valid held high");
  endtask

  initial begin
    test_reset();
    test_parity_even();
    test_parity_odd_stop2();
    test_data_latch();
    test_ignore_busy();
    test_reset_mid_frame();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
